// File: rtl/ifu_pkg.sv
// ifu_pkg: shared constants, types and helpers for the instruction fetch unit.
//
//   INSTR_W       instruction word width (always 32)
//   DEF_ADDR_W    default PC/address width
//   DEF_RESET_PC  default PC loaded on reset
//   fetch_entry_t {pc, instr} pair at the default address width
//   next_pc()     sequential successor of a PC (wraps mod 2^DEF_ADDR_W)
package ifu_pkg;

    localparam int INSTR_W    = 32;
    localparam int DEF_ADDR_W = 32;
    localparam logic [DEF_ADDR_W-1:0] DEF_RESET_PC = '0;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] pc;
        logic [INSTR_W-1:0]    instr;
    } fetch_entry_t;

    function automatic logic [DEF_ADDR_W-1:0] next_pc(input logic [DEF_ADDR_W-1:0] pc);
        return pc + DEF_ADDR_W'(4);
    endfunction

endpackage

// File: rtl/ifu_prefetch_fetch_queue.sv
// fetch_queue: synchronous FIFO with flush, used for the prefetch instruction
// queue and for the PC-tag FIFO that pairs responses with their addresses.
//
// Ports:
//   clock, rst     clock and asynchronous active-high reset
//   flush_i        empties the FIFO at the next edge; overrides push/pop
//   push_i         write push_data_i at the tail
//   pop_i          advance the head (ignored when empty)
//   head_o         current head entry (undefined when empty_o)
//   empty_o/full_o occupancy flags
//   count_o        occupancy, $clog2(DEPTH)+1 bits
//
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [W-1:0]           push_data_i,
    input  logic                   pop_i,
    output logic [W-1:0]           head_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is accepted only when the head leaves the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage carries no reset; contents are only observed while count_q > 0.
    always_ff @(posedge clock) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: instruction fetch unit. Owns the PC, issues word-aligned
// requests to an in-order variable-latency instruction memory and buffers the
// returned words with their PCs for decode. A redirect flushes all speculative
// state; responses still in flight at that moment are counted and discarded.
//
// Ports:
//   clock, rst            clock, asynchronous active-high reset
//   imem_req_valid/addr   fetch request (memory always accepts)
//   imem_rsp_valid/data   in-order response word
//   inst_valid/ready      head-of-queue handshake to decode
//   inst_data/inst_pc     head instruction and its PC (0 while not valid)
//   redirect_valid/pc     new fetch stream; redirect_pc[1:0] ignored
//   stat_fetched          (IFU_STATS_EN) dequeue handshake count
//   stat_redirects        (IFU_STATS_EN) redirect cycle count
//
// Handshake: a word transfers to decode in every cycle where inst_valid and
// inst_ready are both high; inst_valid never depends on inst_ready.
//
// Build option: define IFU_STATS_EN to add the two statistics counters.
// ADDR_W must not exceed 32.
module ifu_prefetch
    import ifu_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic               clock,
    input  logic               rst,
    output logic               imem_req_valid,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [INSTR_W-1:0] inst_data,
    output logic [ADDR_W-1:0]  inst_pc,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc
`ifdef IFU_STATS_EN
    ,
    output logic [31:0]        stat_fetched,
    output logic [31:0]        stat_redirects
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = ADDR_W + INSTR_W;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CW-1:0]     inflight_q, inflight_d;
    logic [CW-1:0]     drop_q, drop_d;
    logic              started_q;

    logic              issue;
    logic              rsp_drop, rsp_keep;
    logic              deq;
    logic [CW:0]       credit_used;
    logic [ADDR_W-1:0] pc_plus4;

    logic [EW-1:0]     iq_head;
    logic              iq_empty, iq_full;
    logic [CW-1:0]     iq_count;
    logic [ADDR_W-1:0] tag_head;
    logic              tag_empty, tag_full;
    logic [CW-1:0]     tag_count;

    // Requests only start one edge after reset releases.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) started_q <= 1'b0;
        else     started_q <= 1'b1;
    end

    // Every request in flight (including ones to be dropped) holds a queue
    // slot, so the instruction queue can never overflow.
    assign credit_used = {1'b0, iq_count} + {1'b0, inflight_q};
    assign issue       = started_q && !redirect_valid && (credit_used < (CW+1)'(DEPTH));

    assign imem_req_valid = issue;
    assign imem_req_addr  = pc_q;

    assign rsp_drop = imem_rsp_valid && (drop_q != '0);
    assign rsp_keep = imem_rsp_valid && (drop_q == '0);

    assign inst_valid = !iq_empty;
    assign deq        = inst_valid && inst_ready;
    assign inst_data  = inst_valid ? iq_head[INSTR_W-1:0] : '0;
    assign inst_pc    = inst_valid ? iq_head[EW-1 -: ADDR_W] : '0;

    assign pc_plus4 = ADDR_W'(next_pc(DEF_ADDR_W'(pc_q)));

    always_comb begin
        pc_d       = pc_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        if (redirect_valid) begin
            // Everything still outstanding after this cycle belongs to the
            // old stream; a response arriving now is discarded with the flush.
            pc_d       = {redirect_pc[ADDR_W-1:2], 2'b00};
            inflight_d = inflight_q - CW'(imem_rsp_valid);
            drop_d     = inflight_q - CW'(imem_rsp_valid);
        end else begin
            if (issue) pc_d = pc_plus4;
            inflight_d = inflight_q + CW'(issue) - CW'(imem_rsp_valid);
            if (rsp_drop) drop_d = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    // PC tags of live (non-dropped) requests, in issue order.
    fetch_queue #(.DEPTH(DEPTH), .W(ADDR_W)) u_tag_fifo (
        .clock       (clock),
        .rst         (rst),
        .flush_i     (redirect_valid),
        .push_i      (issue),
        .push_data_i (pc_q),
        .pop_i       (rsp_keep),
        .head_o      (tag_head),
        .empty_o     (tag_empty),
        .full_o      (tag_full),
        .count_o     (tag_count)
    );

    fetch_queue #(.DEPTH(DEPTH), .W(EW)) u_inst_queue (
        .clock       (clock),
        .rst         (rst),
        .flush_i     (redirect_valid),
        .push_i      (rsp_keep),
        .push_data_i ({tag_head, imem_rsp_data}),
        .pop_i       (deq),
        .head_o      (iq_head),
        .empty_o     (iq_empty),
        .full_o      (iq_full),
        .count_o     (iq_count)
    );

    logic unused_ok;
    assign unused_ok = ^{tag_empty, tag_full, tag_count, iq_full, redirect_pc[1:0]};

`ifdef IFU_STATS_EN
    logic [31:0] stat_fetched_q, stat_redirects_q;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            stat_fetched_q   <= '0;
            stat_redirects_q <= '0;
        end else begin
            if (deq)            stat_fetched_q   <= stat_fetched_q + 32'd1;
            if (redirect_valid) stat_redirects_q <= stat_redirects_q + 32'd1;
        end
    end

    assign stat_fetched   = stat_fetched_q;
    assign stat_redirects = stat_redirects_q;
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
module tb_ifu_prefetch;

    localparam int          ADDR_W = 16;
    localparam int          DEPTH  = 4;
    localparam logic [15:0] RST_PC = 16'h0100;

    logic        clock;
    logic        rst;
    logic        imem_req_valid;
    logic [15:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [15:0] inst_pc;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
`ifdef IFU_STATS_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_redirects;
`endif

    ifu_prefetch #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clock          (clock),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef IFU_STATS_EN
        ,
        .stat_fetched   (stat_fetched),
        .stat_redirects (stat_redirects)
`endif
    );

    // ---------------- clock / reset ----------------
    int cyc = 0;
    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Word stored at each byte address of the instruction memory.
    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {a ^ 16'hC3A5, ~a};
    endfunction

    // ---------------- memory model: in order, latency cur_lat (>=1) ----------------
    typedef struct {
        int          due;
        logic [15:0] addr;
    } mreq_t;
    mreq_t mq[$];
    int    last_due = 0;
    int    cur_lat  = 1;

    always @(negedge clock) begin
        int due;
        if (!rst && imem_req_valid) begin
            due = cyc + cur_lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq.push_back('{due, imem_req_addr});
        end
    end

    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(posedge clock);
            #2;
            if (rst) begin
                mq.delete();
                last_due       = 0;
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
            end else if (mq.size() > 0 && mq[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(mq[0].addr);
                void'(mq.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
            end
        end
    end

    // ---------------- reference model + scoreboard monitor ----------------
    // Decode must see the sequential stream starting at the last reset PC or
    // redirect target (word aligned, 16-bit wrap), each with its memory word.
    logic [47:0] exp_q[$];
    logic [15:0] model_pc;
    logic [15:0] exp_req_pc;
    int          reqs_since_flush;
    int          deq_since_flush;
    int          first_req_cyc = -1;
    int          first_val_cyc = -1;
    int          exp_fetched;
    int          exp_redirects;
    bit          prev_redirect = 1'b0;
    int          starve = 0;
    logic [47:0] exp_e;

    always @(negedge clock) begin
        if (rst) begin
            check("reset_req_valid", 64'(imem_req_valid), 64'(0));
            check("reset_inst_valid", 64'(inst_valid), 64'(0));
            check("reset_inst_data", 64'(inst_data), 64'(0));
            check("reset_inst_pc", 64'(inst_pc), 64'(0));
`ifdef IFU_STATS_EN
            check("reset_stat_fetched", 64'(stat_fetched), 64'(0));
            check("reset_stat_redirects", 64'(stat_redirects), 64'(0));
`endif
            exp_q.delete();
            model_pc         = RST_PC;
            exp_req_pc       = RST_PC;
            reqs_since_flush = 0;
            deq_since_flush  = 0;
            first_req_cyc    = -1;
            first_val_cyc    = -1;
            exp_fetched      = 0;
            exp_redirects    = 0;
            prev_redirect    = 1'b0;
            starve           = 0;
        end else begin
            if (prev_redirect) check("flush_empty", 64'(inst_valid), 64'(0));

            if (redirect_valid) begin
                check("no_req_on_redirect", 64'(imem_req_valid), 64'(0));
            end else if (imem_req_valid) begin
                check("req_addr", 64'(imem_req_addr), 64'(exp_req_pc));
                exp_req_pc = exp_req_pc + 16'd4;
                reqs_since_flush++;
                if (first_req_cyc < 0) first_req_cyc = cyc;
            end

            if (inst_valid && first_val_cyc < 0) first_val_cyc = cyc;

            if (inst_valid && inst_ready) begin
                while (exp_q.size() < 8) begin
                    exp_q.push_back({model_pc, mem_word(model_pc)});
                    model_pc = model_pc + 16'd4;
                end
                exp_e = exp_q.pop_front();
                check("inst_pc_data", 64'({inst_pc, inst_data}), 64'(exp_e));
                deq_since_flush++;
                exp_fetched++;
            end

            if (redirect_valid) begin
                exp_q.delete();
                model_pc         = redirect_pc & 16'hFFFC;
                exp_req_pc       = redirect_pc & 16'hFFFC;
                reqs_since_flush = 0;
                deq_since_flush  = 0;
                exp_redirects++;
            end
            prev_redirect = redirect_valid;

            if (inst_valid || redirect_valid) starve = 0;
            else if (inst_ready) starve++;
            if (starve > 40) begin
                check("fetch_progress_timeout", 64'(starve), 64'(0));
                starve = 0;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
        #1;
    endtask

    int rel_cyc;

    initial begin
        rst            = 1'b1;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        cur_lat        = 1;

        // Sequential fetch from RESET_PC, latency 1, decode always ready.
        repeat (3) tick();
        rst        = 1'b0;
        rel_cyc    = cyc;
        inst_ready = 1'b1;
        repeat (30) tick();
        check("first_req_cycle", 64'(first_req_cyc), 64'(rel_cyc + 1));
        check("first_valid_latency", 64'(first_val_cyc - first_req_cyc), 64'(2));
        for (int i = 0; i < 10; i++) begin
            sample();
            check("stream_one_per_cycle", 64'(inst_valid), 64'(1));
        end

        // Decode stalls: credit limit holds exactly DEPTH words, no more requests.
        tick();
        inst_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i >= 5) begin
                sample();
                check("stall_no_req", 64'(imem_req_valid), 64'(0));
            end
        end
        check("stall_outstanding", 64'(reqs_since_flush - deq_since_flush), 64'(DEPTH));
        tick();
        inst_ready = 1'b1;
        repeat (20) tick();

        // Latency 3 with requests in flight, redirect drops stale responses.
        cur_lat = 3;
        repeat (10) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h2000;
        tick();
        redirect_valid = 1'b0;
        repeat (20) tick();

        // Address wrap at 0xFFFC and low-bit masking of the target.
        cur_lat        = 1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFF3;
        tick();
        redirect_valid = 1'b0;
        repeat (20) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h1237;
        tick();
        redirect_valid = 1'b0;
        repeat (20) tick();

        // Random traffic with a reset in the middle.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                rst            = 1'b1;
                redirect_valid = 1'b0;
                tick();
                tick();
                rst = 1'b0;
            end
            inst_ready     = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = 16'($urandom);
            cur_lat        = $urandom_range(1, 4);
            tick();
        end

        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        cur_lat        = 1;
        repeat (30) tick();
`ifdef IFU_STATS_EN
        sample();
        check("stat_fetched", 64'(stat_fetched), 64'(exp_fetched));
        check("stat_redirects", 64'(stat_redirects), 64'(exp_redirects));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
